conv_window_buffer: RTL and testbench
=====================================

# conv_window_buffer

Streaming line-buffer stage directly upstream of the `convolve_window` datapath. It accepts one signed 16-bit fixed-point pixel per cycle in raster order and keeps the last K−1 image rows on chip. For every valid stride-1, unpadded K×K position (K = 3 or 5) it presents a registered 25-entry window, laid out the way the convolver's window input expects.

## Interface
Parameters:
- `DATA_W`, 16: pixel width, signed fixed point, passed through unmodified.
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: frame start pulse; sampled only in IDLE.
- `filter_size`, in, 3: K, latched on `start`; 3 selects 3×3, any other value selects 5×5.
- `in_valid`, in, 1: `in_pixel` is valid.
- `in_ready`, out, 1: stage can accept a pixel.
- `in_pixel`, in, DATA_W: signed pixel.
- `out_valid`, out, 1: `window` holds a complete window.
- `out_ready`, in, 1: consumer takes the window.
- `window[0:24]`, out, DATA_W each: signed, row-major 5×5 grid.
- `frame_done`, out, 1: one-cycle pulse after the frame's last window is taken.

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN on `start`. This clears the row/column counters and latches K.
  - RUN → IDLE in the cycle `frame_done` pulses.
  - `start` is ignored while in RUN.
- Pixel acceptance:
  - A pixel is accepted when `in_valid && in_ready`.
  - `in_ready = (state==RUN) && !last_accepted && (!out_valid || out_ready)`.
- Counters `row` and `col` track the accepted pixel position.
  - `col` wraps at IMG_W−1, and `row` increments on the wrap.
  - `last_accepted` sets when pixel (IMG_H−1, IMG_W−1) is accepted.
- Storage:
  - Four cascaded row delays of IMG_W entries each. Only the first K−1 rows are used.
  - A 5×5 shift-register window, shifted left by one column per accepted pixel.
- A window completes when the accepted pixel has `row ≥ K−1 && col ≥ K−1`.
  - Window entry (r,c) = pixel (row−K+1+r, col−K+1+c), stored at `window[r*5+c]` for r,c < K.
  - All entries with r ≥ K or c ≥ K are driven 0.
  - Entry 0 is the oldest top-left pixel.
- Each frame yields exactly (IMG_H−K+1)·(IMG_W−K+1) windows.
- No arithmetic is performed; values pass through with sign preserved.
- `frame_done` pulses once the last window has been handshaken; the FSM then returns to IDLE.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=0, `frame_done`=0, all `window` entries 0.
  - State IDLE, counters 0, latched K=5.
- Latency: `out_valid` rises in the cycle after the completing pixel is accepted, with `window` registered in that same edge.
- Holding: `out_valid` and `window` stay stable until `out_valid && out_ready`.
- Simultaneous events: handshake of the current window and acceptance of the next completing pixel in the same cycle keeps `out_valid` high and loads the new window.
- Throughput: one pixel per cycle when `out_ready` is held high. Non-completing pixels are never blocked by a pending window unless `out_valid && !out_ready`.
- `in_valid` bubbles insert idle cycles only; no state changes.
- `frame_done` is asserted in the cycle after the final window's handshake, for exactly 1 cycle.
- Reset mid-frame aborts immediately to the reset values. Line-buffer RAM contents need not be cleared, because the next frame overwrites them before use.

## Structure
- Shared package `cnn_pkg`:
  - `DATA_W=16`, `MAX_K=5`, `WIN_LEN=25`.
  - `typedef logic signed [DATA_W-1:0] pixel_t`.
  - `typedef pixel_t window_t [0:WIN_LEN-1]`.
- Sub-module `row_delay`: a one-row delay line of IMG_W entries with shift enable. It is instantiated four times.

## Test plan
Bench overrides IMG_W=IMG_H=6. Pixel p(r,c) = (r*6+c)<<11 unless stated.
- **K=5, `out_ready` held 1:**
  - Exactly 4 windows.
  - First window: `window[0]`=0, `window[24]`=28<<11.
  - Last window: `window[0]`=7<<11, `window[24]`=35<<11.
  - `frame_done` pulses once, 1 cycle after the 4th handshake.
- **K=3:**
  - 16 windows.
  - First window: `window[1]`=1<<11, `window[5]`=6<<11, `window[12]`=14<<11.
  - `window[3,4,8,9,13..24]`=0.
- **Backpressure:**
  - Hold `out_ready`=0 for 3 cycles while the first window is valid.
  - `in_ready`=0 throughout and `window` stable.
  - The window sequence is identical to the first scenario.
- **Input bubbles:** randomly deassert `in_valid` about 30% of cycles; window sequence and count are identical to the first scenario.
- **Reset mid-frame:**
  - Assert `rst_n`=0 after 20 accepted pixels.
  - All outputs take reset values.
  - A new `start` with K=5 yields a correct first window.
- **Sign preservation:** all pixels 16'hB000, K=5; every `window` entry equals 16'hB000.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN window datapath.
// The window is always carried as a fixed 5x5 row-major grid.
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_K   = 5;
    localparam int WIN_LEN = 25;

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef pixel_t window_t [0:WIN_LEN-1];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A filter_size of exactly 3 selects 3x3; anything else selects 5x5.
    function automatic logic k_is_3(input logic [2:0] fs);
        return (fs == 3'd3);
    endfunction

endpackage

// File: rtl/conv_window_buffer_row_delay.sv
// One image-row delay line: on each enable, dout is the sample written DEPTH enables earlier.
// Contents are never reset; a new frame refills them before any window uses them.
module row_delay #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 28
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);

    logic signed [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic signed [DATA_W-1:0] mem_d [0:DEPTH-1];

    // next-state of the shift chain
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // storage update
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_buffer.sv
// Line buffer feeding convolve_window: keeps K-1 rows and emits a registered
// 5x5 row-major window for every valid unpadded stride-1 KxK position.
module conv_window_buffer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               filter_size,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] window [0:24],
    output logic                     frame_done
);

    import cnn_pkg::*;

    localparam int CNT_W = $clog2(IMG_W + IMG_H + 8);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

    typedef logic signed [DATA_W-1:0] pix_t;

    state_e           state_q, state_d;
    logic             k3_q, k3_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;

    pix_t sr_q  [0:MAX_K-1][0:MAX_K-1];
    pix_t sr_d  [0:MAX_K-1][0:MAX_K-1];
    pix_t win_q [0:WIN_LEN-1];
    pix_t win_d [0:WIN_LEN-1];

    pix_t tap_s    [0:3];
    pix_t rd_in_s  [0:3];
    pix_t col_in_s [0:MAX_K-1];

    logic             in_ready_s;
    logic             accept_s;
    logic             complete_s;
    logic             final_hs_s;
    logic [CNT_W-1:0] km1_s;

    // handshake and window-completion decode
    always_comb begin
        km1_s      = k3_q ? CNT_W'(3'd2) : CNT_W'(3'd4);
        in_ready_s = (state_q == ST_RUN) && !last_q && (!out_valid_q || out_ready);
        accept_s   = in_valid && in_ready_s;
        complete_s = accept_s && (row_q >= km1_s) && (col_q >= km1_s);
        final_hs_s = (state_q == ST_RUN) && last_q && out_valid_q && out_ready;
    end

    // row delay cascade inputs: each stage feeds from the previous stage's output
    always_comb begin
        rd_in_s[0] = in_pixel;
        for (int i = 1; i < 4; i++) begin
            rd_in_s[i] = tap_s[i-1];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_rd
        row_delay #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_row_delay (
            .clk  (clk),
            .en   (accept_s),
            .din  (rd_in_s[g]),
            .dout (tap_s[g])
        );
    end

    // FSM, position counters and output-handshake next state
    always_comb begin
        state_d      = state_q;
        k3_d         = k3_q;
        row_d        = row_q;
        col_d        = col_q;
        last_d       = last_q;
        frame_done_d = final_hs_s;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    k3_d    = k_is_3(filter_size);
                    row_d   = '0;
                    col_d   = '0;
                    last_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + CNT_W'(1'b1);
                    end else begin
                        col_d = col_q + CNT_W'(1'b1);
                    end
                    if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                        last_d = 1'b1;
                    end else begin
                        last_d = last_q;
                    end
                end else begin
                    col_d = col_q;
                end
                if (final_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // a new completing pixel wins over retiring the current window
        if (complete_s) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // newest column: oldest row on top, current pixel at the bottom of the K rows
    always_comb begin
        if (k3_q) begin
            col_in_s[0] = tap_s[1];
            col_in_s[1] = tap_s[0];
            col_in_s[2] = in_pixel;
            col_in_s[3] = '0;
            col_in_s[4] = '0;
        end else begin
            col_in_s[0] = tap_s[3];
            col_in_s[1] = tap_s[2];
            col_in_s[2] = tap_s[1];
            col_in_s[3] = tap_s[0];
            col_in_s[4] = in_pixel;
        end
    end

    // shift window register left one column; new column lands at column K-1
    always_comb begin
        sr_d = sr_q;
        if (accept_s) begin
            for (int r = 0; r < MAX_K; r++) begin
                for (int c = 0; c < MAX_K - 1; c++) begin
                    sr_d[r][c] = sr_q[r][c+1];
                end
                if (k3_q) begin
                    sr_d[r][2] = col_in_s[r];
                end else begin
                    sr_d[r][4] = col_in_s[r];
                end
            end
        end else begin
            sr_d = sr_q;
        end
    end

    // capture the completed window, zeroing entries outside the KxK region
    always_comb begin
        win_d = win_q;
        if (complete_s) begin
            for (int r = 0; r < MAX_K; r++) begin
                for (int c = 0; c < MAX_K; c++) begin
                    if (k3_q && ((r >= 3) || (c >= 3))) begin
                        win_d[r*MAX_K + c] = '0;
                    end else begin
                        win_d[r*MAX_K + c] = sr_d[r][c];
                    end
                end
            end
        end else begin
            win_d = win_q;
        end
    end

    // control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            k3_q         <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            last_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k3_q         <= k3_d;
            row_q        <= row_d;
            col_q        <= col_d;
            last_q       <= last_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // window datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < MAX_K; r++) begin
                for (int c = 0; c < MAX_K; c++) begin
                    sr_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < WIN_LEN; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            sr_q  <= sr_d;
            win_q <= win_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign window     = win_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Randomised bench for conv_window_buffer on a 6x6 image, checked against a
// reference that slices each expected KxK window straight out of the frame array.
module tb_conv_window_buffer;

    localparam int W = 6;
    localparam int H = 6;
    localparam int NPIX = W * H;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        filter_size;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] window [0:24];
    logic              frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]  pix [0:NPIX-1];
    logic [399:0] exp_q [$];
    logic [399:0] first_win;
    logic [399:0] last_win;
    int           nwin;

    conv_window_buffer #(
        .DATA_W (16),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .filter_size (filter_size),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .window      (window),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [399:0] got, input logic [399:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [399:0] pack_win();
        logic [399:0] v;
        v = '0;
        for (int i = 0; i < 25; i++) begin
            v[i*16 +: 16] = window[i];
        end
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, out_valid, 1'b0);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_frame_done"}, frame_done, 1'b0);
        check_eq({tag, "_window"}, pack_win(), 400'd0);
    endtask

    // Runs one frame. Returns early (after handing over pixel abort_after) when abort_after > 0.
    task automatic run_frame(input logic [2:0] fs, input int pmode, input int or_mode,
                             input int iv_pct, input bit glitch, input int abort_after);
        int           k;
        int           idx;
        int           bp_cycles;
        bit           done;
        bit           hs_prev;
        logic [399:0] w;

        k = (fs == 3'd3) ? 3 : 5;
        for (int i = 0; i < NPIX; i++) begin
            case (pmode)
                0:       pix[i] = 16'(i * 2048);
                1:       pix[i] = 16'hB000;
                default: pix[i] = 16'($urandom);
            endcase
        end
        exp_q.delete();
        for (int r0 = 0; r0 <= H - k; r0++) begin
            for (int c0 = 0; c0 <= W - k; c0++) begin
                w = '0;
                for (int r = 0; r < k; r++) begin
                    for (int c = 0; c < k; c++) begin
                        w[(r*5 + c)*16 +: 16] = pix[(r0 + r)*W + c0 + c];
                    end
                end
                exp_q.push_back(w);
            end
        end

        @(negedge clk);
        start       = 1'b1;
        filter_size = fs;
        in_valid    = 1'b0;
        @(negedge clk);
        start = 1'b0;

        idx = 0; bp_cycles = 0; done = 1'b0; hs_prev = 1'b0; nwin = 0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(negedge clk);
            in_valid = (idx < NPIX) && ($urandom_range(99) >= iv_pct);
            in_pixel = (idx < NPIX) ? pix[idx] : 16'sd0;
            if (glitch && idx < NPIX - 6) begin
                start       = ($urandom_range(3) == 0);
                filter_size = 3'd3;
            end else begin
                start = 1'b0;
            end
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(out_valid && bp_cycles < 3);
                default: out_ready = $urandom_range(1);
            endcase
            if (out_valid && !out_ready) bp_cycles++;
            #1;
            check_eq("frame_done", frame_done, hs_prev);
            if (frame_done) done = 1'b1;
            check_eq("in_ready", in_ready,
                     (idx < NPIX) && !done && (!out_valid || out_ready));
            hs_prev = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_window", out_valid, 1'b0);
                end else begin
                    check_eq("window", pack_win(), exp_q[0]);
                    if (out_ready) begin
                        if (nwin == 0) first_win = pack_win();
                        last_win = pack_win();
                        void'(exp_q.pop_front());
                        nwin++;
                        hs_prev = (exp_q.size() == 0);
                    end
                end
            end
            if (in_valid && in_ready) begin
                idx++;
                if (abort_after > 0 && idx == abort_after) return;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check_eq("frame_done_seen", done, 1'b1);
        check_eq("window_count", nwin, (H - k + 1) * (W - k + 1));
        @(negedge clk);
        #1;
        check_eq("frame_done_once", frame_done, 1'b0);
        check_eq("idle_in_ready", in_ready, 1'b0);
        check_eq("idle_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        logic [399:0] z;
        rst_n = 1'b0; start = 1'b0; filter_size = 3'd5;
        in_valid = 1'b0; in_pixel = 16'sd0; out_ready = 1'b0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // K=5, out_ready high
        run_frame(3'd5, 0, 0, 0, 1'b0, 0);
        check_eq("k5_first_w0",  first_win[0*16 +: 16],  16'h0000);
        check_eq("k5_first_w24", first_win[24*16 +: 16], 16'hE000);
        check_eq("k5_last_w0",   last_win[0*16 +: 16],   16'h3800);
        check_eq("k5_last_w24",  last_win[24*16 +: 16],  16'h1800);

        // K=3
        run_frame(3'd3, 0, 0, 0, 1'b0, 0);
        check_eq("k3_first_w1",  first_win[1*16 +: 16],  16'h0800);
        check_eq("k3_first_w5",  first_win[5*16 +: 16],  16'h3000);
        check_eq("k3_first_w12", first_win[12*16 +: 16], 16'h7000);
        z = '0;
        for (int i = 0; i < 25; i++) begin
            if ((i / 5) >= 3 || (i % 5) >= 3) z[i*16 +: 16] = first_win[i*16 +: 16];
        end
        check_eq("k3_zero_pad", z, 400'd0);

        // backpressure on first window, non-3 code selects 5x5
        run_frame(3'd7, 0, 1, 0, 1'b0, 0);
        // input bubbles with stray start pulses during the frame
        run_frame(3'd5, 0, 0, 30, 1'b1, 0);
        // random pixels, random out_ready, bubbles, K=3 and K=5
        run_frame(3'd3, 2, 2, 30, 1'b0, 0);
        run_frame(3'd5, 2, 2, 20, 1'b0, 0);

        // reset mid-frame after 20 accepted pixels
        run_frame(3'd5, 0, 0, 0, 1'b0, 20);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(3'd5, 0, 0, 0, 1'b0, 0);
        check_eq("post_reset_first_w24", first_win[24*16 +: 16], 16'hE000);

        // sign preservation
        run_frame(3'd5, 1, 0, 0, 1'b0, 0);
        check_eq("sign_w0", first_win[0*16 +: 16], 16'hB000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
